// File: rtl/if_fetch_queue_if.sv
// Fetch-queue signal bundle: instruction memory port, redirect input and decode port.
// master is the fetch queue; slave is the memory/decode/branch side.
interface if_fetch_queue_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;

    modport master (
        output imem_req, imem_addr, id_valid, id_instr, id_pc,
        input  imem_ack, imem_rdata, redirect_valid, redirect_pc, id_ready
    );

    modport slave (
        input  imem_req, imem_addr, id_valid, id_instr, id_pc,
        output imem_ack, imem_rdata, redirect_valid, redirect_pc, id_ready
    );
endinterface

// File: rtl/if_fetch_queue.sv
// Instruction fetch stage: one-outstanding imem requests feeding a small PC/instruction FIFO,
// flushed and restarted by branch/jump redirects.
module if_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    if_fetch_queue_if.master      bus
);
    localparam int unsigned XLEN  = 32;
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

    state_t             state_q, state_d;
    logic [XLEN-1:0]    fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]    req_addr_q, req_addr_d;
    logic               imem_req_q, imem_req_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [XLEN-1:0]    pc_mem_q    [DEPTH];
    logic [XLEN-1:0]    pc_mem_d    [DEPTH];
    logic [XLEN-1:0]    instr_mem_q [DEPTH];
    logic [XLEN-1:0]    instr_mem_d [DEPTH];

    logic               id_valid_c;
    logic               push_c;
    logic               pop_c;
    logic               space_c;

    assign id_valid_c    = (count_q != '0);
    assign bus.id_valid  = id_valid_c;
    assign bus.id_instr  = id_valid_c ? instr_mem_q[rd_ptr_q] : '0;
    assign bus.id_pc     = id_valid_c ? pc_mem_q[rd_ptr_q]    : '0;
    assign bus.imem_req  = imem_req_q;
    assign bus.imem_addr = req_addr_q;

    // Next-state: FIFO bookkeeping first, so the slot check sees this cycle's push/pop.
    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        req_addr_d  = req_addr_q;
        count_d     = count_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        pc_mem_d    = pc_mem_q;
        instr_mem_d = instr_mem_q;

        push_c = (state_q == REQ) && bus.imem_ack && !bus.redirect_valid;
        pop_c  = id_valid_c && bus.id_ready && !bus.redirect_valid;

        if (bus.redirect_valid) begin
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            fetch_pc_d = bus.redirect_pc;
        end else begin
            count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
            if (push_c) begin
                pc_mem_d[wr_ptr_q]    = req_addr_q;
                instr_mem_d[wr_ptr_q] = bus.imem_rdata;
                wr_ptr_d              = wr_ptr_q + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
        end

        space_c = (count_d < CNT_W'(DEPTH));

        case (state_q)
            IDLE: begin
                if (!bus.redirect_valid && space_c) begin
                    state_d    = REQ;
                    req_addr_d = fetch_pc_q;
                    fetch_pc_d = fetch_pc_q + 32'd4;
                end
            end
            REQ: begin
                if (bus.redirect_valid) begin
                    // An un-acked request must still complete; its data is dropped.
                    state_d = bus.imem_ack ? IDLE : DROP;
                end else if (bus.imem_ack) begin
                    if (space_c) begin
                        req_addr_d = fetch_pc_q;
                        fetch_pc_d = fetch_pc_q + 32'd4;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DROP: begin
                if (bus.imem_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        imem_req_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            req_addr_q <= '0;
            imem_req_q <= 1'b0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_addr_q <= req_addr_d;
            imem_req_q <= imem_req_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    // Entry storage needs no reset; id_* are masked by id_valid.
    always_ff @(posedge clk) begin
        pc_mem_q    <= pc_mem_d;
        instr_mem_q <= instr_mem_d;
    end
endmodule

// File: tb/tb_if_fetch_queue.sv
// Self-checking bench for if_fetch_queue: directed scenarios plus a randomized run
// checked against a transaction-level queue model.
module tb_if_fetch_queue;
    localparam int unsigned DEPTH   = 4;
    localparam logic [31:0] XOR_PAT = 32'hA5A5_0000;

    logic clk = 1'b0;
    logic rst;
    int   n_tests;
    int   n_fail;

    int   mem_wait;
    int   max_wait;
    int   wcnt;
    int   ack_force;
    bit   ack_tie;
    bit   rand_data;

    if_fetch_queue_if bus_if ();

    if_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs at the falling edge; also acts as the instruction memory.
    task automatic tick(input logic r, input logic rdy, input logic rv, input logic [31:0] rpc);
        @(negedge clk);
        rst                   = r;
        bus_if.id_ready       = rdy;
        bus_if.redirect_valid = rv;
        bus_if.redirect_pc    = rpc;
        if (ack_force >= 0) begin
            bus_if.imem_ack = ack_force[0];
        end else if (bus_if.imem_req) begin
            if (wcnt >= mem_wait) begin
                bus_if.imem_ack = 1'b1;
                wcnt = 0;
                if (max_wait > 0) mem_wait = $urandom_range(0, max_wait);
            end else begin
                bus_if.imem_ack = 1'b0;
                wcnt++;
            end
        end else begin
            bus_if.imem_ack = ack_tie;
            wcnt = 0;
        end
        bus_if.imem_rdata = rand_data ? $urandom : (bus_if.imem_addr ^ XOR_PAT);
    endtask

    task automatic do_reset(input logic rdy);
        wcnt = 0;
        tick(1'b1, 1'b0, 1'b0, 32'h0);
        tick(1'b1, 1'b0, 1'b0, 32'h0);
        tick(1'b0, rdy, 1'b0, 32'h0);
    endtask

    task automatic test_reset();
        ack_tie = 1'b1; ack_force = -1; mem_wait = 0; max_wait = 0;
        tick(1'b1, 1'b1, 1'b0, 32'h0);
        tick(1'b1, 1'b1, 1'b0, 32'h0);
        n_tests++;
        if ({bus_if.imem_req, bus_if.imem_addr} !== 33'h0) begin
            n_fail++; $display("FAIL reset_imem: req/addr got %0d/%h expected 0/0", bus_if.imem_req, bus_if.imem_addr);
        end
        n_tests++;
        if ({bus_if.id_valid, bus_if.id_instr, bus_if.id_pc} !== 65'h0) begin
            n_fail++; $display("FAIL reset_id: valid/instr/pc got %0d/%h/%h expected 0/0/0", bus_if.id_valid, bus_if.id_instr, bus_if.id_pc);
        end
        tick(1'b0, 1'b1, 1'b0, 32'h0);
        n_tests++;
        if (bus_if.imem_req !== 1'b0) begin
            n_fail++; $display("FAIL reset_release_req: got %0d expected 0", bus_if.imem_req);
        end
    endtask

    task automatic test_boot();
        logic [31:0] exp_pc;
        tick(1'b0, 1'b1, 1'b0, 32'h0);
        n_tests++;
        if ({bus_if.imem_req, bus_if.imem_addr} !== {1'b1, 32'h0}) begin
            n_fail++; $display("FAIL boot_first_req: req/addr got %0d/%h expected 1/0", bus_if.imem_req, bus_if.imem_addr);
        end
        exp_pc = 32'h0;
        for (int i = 0; i < 8; i++) begin
            tick(1'b0, 1'b1, 1'b0, 32'h0);
            n_tests++;
            if ({bus_if.id_valid, bus_if.id_pc, bus_if.id_instr} !== {1'b1, exp_pc, exp_pc ^ XOR_PAT}) begin
                n_fail++; $display("FAIL boot_stream[%0d]: valid/pc/instr got %0d/%h/%h expected 1/%h/%h",
                                   i, bus_if.id_valid, bus_if.id_pc, bus_if.id_instr, exp_pc, exp_pc ^ XOR_PAT);
            end
            n_tests++;
            if ({bus_if.imem_req, bus_if.imem_addr} !== {1'b1, exp_pc + 32'd4}) begin
                n_fail++; $display("FAIL boot_b2b_req[%0d]: req/addr got %0d/%h expected 1/%h", i, bus_if.imem_req, bus_if.imem_addr, exp_pc + 32'd4);
            end
            exp_pc += 32'd4;
        end
    endtask

    task automatic test_full_stall();
        int n_xfer;
        ack_tie = 1'b0;
        do_reset(1'b0);
        n_xfer = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1'b0, 1'b0, 1'b0, 32'h0);
            if (bus_if.imem_req && bus_if.imem_ack) begin
                n_tests++;
                if (bus_if.imem_addr !== 32'(n_xfer * 4)) begin
                    n_fail++; $display("FAIL stall_fill_addr: got %h expected %h", bus_if.imem_addr, 32'(n_xfer * 4));
                end
                n_xfer++;
            end
            if (bus_if.id_valid) begin
                n_tests++;
                if (bus_if.id_pc !== 32'h0) begin
                    n_fail++; $display("FAIL stall_head_stable: pc got %h expected 0", bus_if.id_pc);
                end
            end
        end
        n_tests++;
        if (n_xfer !== 4 || bus_if.imem_req !== 1'b0) begin
            n_fail++; $display("FAIL stall_fill_count: xfers/req got %0d/%0d expected 4/0", n_xfer, bus_if.imem_req);
        end
        tick(1'b0, 1'b1, 1'b0, 32'h0);
        n_tests++;
        if ({bus_if.id_valid, bus_if.id_pc} !== {1'b1, 32'h0}) begin
            n_fail++; $display("FAIL stall_pop_head: valid/pc got %0d/%h expected 1/0", bus_if.id_valid, bus_if.id_pc);
        end
        n_xfer = 0;
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, 1'b0, 1'b0, 32'h0);
            if (bus_if.imem_req && bus_if.imem_ack) begin
                n_tests++;
                if (bus_if.imem_addr !== 32'h10) begin
                    n_fail++; $display("FAIL stall_refill_addr: got %h expected 00000010", bus_if.imem_addr);
                end
                n_xfer++;
            end
        end
        n_tests++;
        if (n_xfer !== 1) begin
            n_fail++; $display("FAIL stall_refill_count: got %0d expected 1", n_xfer);
        end
        // Drain while refetching: push and pop together must keep order.
        for (int i = 0; i < 6; i++) begin
            tick(1'b0, 1'b1, 1'b0, 32'h0);
            n_tests++;
            if ({bus_if.id_valid, bus_if.id_pc, bus_if.id_instr} !== {1'b1, 32'(4 + 4 * i), 32'(4 + 4 * i) ^ XOR_PAT}) begin
                n_fail++; $display("FAIL stall_drain_order[%0d]: valid/pc got %0d/%h expected 1/%h", i, bus_if.id_valid, bus_if.id_pc, 32'(4 + 4 * i));
            end
        end
    endtask

    task automatic test_wait_states();
        int          n_xfer;
        logic [31:0] exp_addr, exp_pop, prev_addr;
        logic        prev_pending;
        mem_wait = 3;
        do_reset(1'b1);
        n_xfer = 0; exp_addr = 0; exp_pop = 0; prev_pending = 1'b0; prev_addr = 0;
        for (int i = 0; i < 40; i++) begin
            tick(1'b0, 1'b1, 1'b0, 32'h0);
            if (prev_pending) begin
                n_tests++;
                if ({bus_if.imem_req, bus_if.imem_addr} !== {1'b1, prev_addr}) begin
                    n_fail++; $display("FAIL wait_hold: req/addr got %0d/%h expected 1/%h", bus_if.imem_req, bus_if.imem_addr, prev_addr);
                end
            end
            if (bus_if.id_valid) begin
                n_tests++;
                if (bus_if.id_pc !== exp_pop || bus_if.id_instr !== (exp_pop ^ XOR_PAT)) begin
                    n_fail++; $display("FAIL wait_order: pc got %h expected %h", bus_if.id_pc, exp_pop);
                end
                exp_pop += 32'd4;
            end
            if (bus_if.imem_req && bus_if.imem_ack) begin
                n_tests++;
                if (bus_if.imem_addr !== exp_addr) begin
                    n_fail++; $display("FAIL wait_addr: got %h expected %h", bus_if.imem_addr, exp_addr);
                end
                exp_addr += 32'd4;
                n_xfer++;
            end
            prev_pending = bus_if.imem_req && !bus_if.imem_ack;
            prev_addr    = bus_if.imem_addr;
        end
        n_tests++;
        if (n_xfer !== 10) begin
            n_fail++; $display("FAIL wait_xfer_count: got %0d expected 10", n_xfer);
        end
        mem_wait = 0;
    endtask

    task automatic test_redirect_midflight();
        do_reset(1'b0);
        tick(1'b0, 1'b0, 1'b0, 32'h0);
        tick(1'b0, 1'b0, 1'b0, 32'h0);
        ack_force = 0;
        tick(1'b0, 1'b0, 1'b1, 32'h100);
        n_tests++;
        if ({bus_if.id_valid, bus_if.imem_addr} !== {1'b1, 32'h8}) begin
            n_fail++; $display("FAIL redir_setup: valid/addr got %0d/%h expected 1/8", bus_if.id_valid, bus_if.imem_addr);
        end
        tick(1'b0, 1'b0, 1'b0, 32'h0);
        n_tests++;
        if ({bus_if.id_valid, bus_if.imem_req, bus_if.imem_addr} !== {2'b01, 32'h8}) begin
            n_fail++; $display("FAIL redir_flush_drop: valid/req/addr got %0d/%0d/%h expected 0/1/8", bus_if.id_valid, bus_if.imem_req, bus_if.imem_addr);
        end
        ack_force = 1;
        tick(1'b0, 1'b0, 1'b0, 32'h0);
        n_tests++;
        if ({bus_if.id_valid, bus_if.imem_req, bus_if.imem_addr} !== {2'b01, 32'h8}) begin
            n_fail++; $display("FAIL redir_drop_hold: valid/req/addr got %0d/%0d/%h expected 0/1/8", bus_if.id_valid, bus_if.imem_req, bus_if.imem_addr);
        end
        ack_force = -1; wcnt = 0;
        tick(1'b0, 1'b0, 1'b0, 32'h0);
        n_tests++;
        if ({bus_if.id_valid, bus_if.imem_req} !== 2'b00) begin
            n_fail++; $display("FAIL redir_stale: valid/req got %0d/%0d expected 0/0", bus_if.id_valid, bus_if.imem_req);
        end
        tick(1'b0, 1'b0, 1'b0, 32'h0);
        n_tests++;
        if ({bus_if.imem_req, bus_if.imem_addr} !== {1'b1, 32'h100}) begin
            n_fail++; $display("FAIL redir_new_req: req/addr got %0d/%h expected 1/100", bus_if.imem_req, bus_if.imem_addr);
        end
        tick(1'b0, 1'b0, 1'b0, 32'h0);
        n_tests++;
        if ({bus_if.id_valid, bus_if.id_pc, bus_if.id_instr} !== {1'b1, 32'h100, 32'hA5A5_0100}) begin
            n_fail++; $display("FAIL redir_first_pc: valid/pc/instr got %0d/%h/%h expected 1/100/a5a50100", bus_if.id_valid, bus_if.id_pc, bus_if.id_instr);
        end
    endtask

    task automatic test_same_cycle();
        do_reset(1'b0);
        tick(1'b0, 1'b0, 1'b0, 32'h0);
        tick(1'b0, 1'b0, 1'b0, 32'h0);
        tick(1'b0, 1'b1, 1'b1, 32'h200);
        n_tests++;
        if ({bus_if.id_valid, bus_if.id_pc, bus_if.imem_req, bus_if.imem_ack, bus_if.imem_addr} !== {1'b1, 32'h0, 2'b11, 32'h8}) begin
            n_fail++; $display("FAIL same_setup: valid/pc/req/ack/addr got %0d/%h/%0d/%0d/%h expected 1/0/1/1/8",
                               bus_if.id_valid, bus_if.id_pc, bus_if.imem_req, bus_if.imem_ack, bus_if.imem_addr);
        end
        tick(1'b0, 1'b0, 1'b0, 32'h0);
        n_tests++;
        if ({bus_if.id_valid, bus_if.imem_req} !== 2'b00) begin
            n_fail++; $display("FAIL same_flush: valid/req got %0d/%0d expected 0/0", bus_if.id_valid, bus_if.imem_req);
        end
        tick(1'b0, 1'b0, 1'b0, 32'h0);
        n_tests++;
        if ({bus_if.imem_req, bus_if.imem_addr} !== {1'b1, 32'h200}) begin
            n_fail++; $display("FAIL same_new_req: req/addr got %0d/%h expected 1/200", bus_if.imem_req, bus_if.imem_addr);
        end
        for (int i = 0; i < 2; i++) begin
            tick(1'b0, 1'b1, 1'b0, 32'h0);
            n_tests++;
            if ({bus_if.id_valid, bus_if.id_pc} !== {1'b1, 32'(32'h200 + 4 * i)}) begin
                n_fail++; $display("FAIL same_order[%0d]: valid/pc got %0d/%h expected 1/%h", i, bus_if.id_valid, bus_if.id_pc, 32'(32'h200 + 4 * i));
            end
        end
    endtask

    task automatic test_pc_wrap();
        logic [31:0] exp_pc;
        do_reset(1'b1);
        tick(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF8);
        tick(1'b0, 1'b1, 1'b0, 32'h0);
        tick(1'b0, 1'b1, 1'b0, 32'h0);
        n_tests++;
        if ({bus_if.imem_req, bus_if.imem_addr} !== {1'b1, 32'hFFFF_FFF8}) begin
            n_fail++; $display("FAIL wrap_req: req/addr got %0d/%h expected 1/fffffff8", bus_if.imem_req, bus_if.imem_addr);
        end
        exp_pc = 32'hFFFF_FFF8;
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, 1'b1, 1'b0, 32'h0);
            n_tests++;
            if ({bus_if.id_valid, bus_if.id_pc} !== {1'b1, exp_pc}) begin
                n_fail++; $display("FAIL wrap_seq[%0d]: valid/pc got %0d/%h expected 1/%h", i, bus_if.id_valid, bus_if.id_pc, exp_pc);
            end
            exp_pc += 32'd4;
        end
    endtask

    task automatic test_reset_midop();
        do_reset(1'b0);
        repeat (3) tick(1'b0, 1'b0, 1'b0, 32'h0);
        ack_force = 0;
        tick(1'b0, 1'b0, 1'b0, 32'h0);
        n_tests++;
        if ({bus_if.id_valid, bus_if.id_pc, bus_if.imem_req, bus_if.imem_addr} !== {1'b1, 32'h0, 1'b1, 32'hC}) begin
            n_fail++; $display("FAIL rstmid_setup: valid/pc/req/addr got %0d/%h/%0d/%h expected 1/0/1/c",
                               bus_if.id_valid, bus_if.id_pc, bus_if.imem_req, bus_if.imem_addr);
        end
        tick(1'b1, 1'b0, 1'b0, 32'h0);
        tick(1'b0, 1'b0, 1'b0, 32'h0);
        n_tests++;
        if ({bus_if.imem_req, bus_if.imem_addr, bus_if.id_valid, bus_if.id_instr, bus_if.id_pc} !== 98'h0) begin
            n_fail++; $display("FAIL rstmid_req_outputs: req/addr/valid got %0d/%h/%0d expected 0/0/0", bus_if.imem_req, bus_if.imem_addr, bus_if.id_valid);
        end
        ack_force = -1; wcnt = 0;
        tick(1'b0, 1'b0, 1'b0, 32'h0);
        n_tests++;
        if ({bus_if.imem_req, bus_if.imem_addr} !== {1'b1, 32'h0}) begin
            n_fail++; $display("FAIL rstmid_restart: req/addr got %0d/%h expected 1/0", bus_if.imem_req, bus_if.imem_addr);
        end
        ack_force = 0;
        tick(1'b0, 1'b0, 1'b1, 32'h40);
        tick(1'b1, 1'b0, 1'b0, 32'h0);
        n_tests++;
        if ({bus_if.imem_req, bus_if.imem_addr, bus_if.id_valid} !== {1'b1, 32'h4, 1'b0}) begin
            n_fail++; $display("FAIL rstmid_in_drop: req/addr/valid got %0d/%h/%0d expected 1/4/0", bus_if.imem_req, bus_if.imem_addr, bus_if.id_valid);
        end
        tick(1'b0, 1'b0, 1'b0, 32'h0);
        n_tests++;
        if ({bus_if.imem_req, bus_if.imem_addr, bus_if.id_valid, bus_if.id_instr, bus_if.id_pc} !== 98'h0) begin
            n_fail++; $display("FAIL rstmid_drop_outputs: req/addr/valid got %0d/%h/%0d expected 0/0/0", bus_if.imem_req, bus_if.imem_addr, bus_if.id_valid);
        end
        ack_force = -1; wcnt = 0;
        tick(1'b0, 1'b0, 1'b0, 32'h0);
        n_tests++;
        if ({bus_if.imem_req, bus_if.imem_addr} !== {1'b1, 32'h0}) begin
            n_fail++; $display("FAIL rstmid_drop_restart: req/addr got %0d/%h expected 1/0", bus_if.imem_req, bus_if.imem_addr);
        end
        tick(1'b0, 1'b1, 1'b0, 32'h0);
        n_tests++;
        if ({bus_if.id_valid, bus_if.id_pc} !== {1'b1, 32'h0}) begin
            n_fail++; $display("FAIL rstmid_first_pc: valid/pc got %0d/%h expected 1/0", bus_if.id_valid, bus_if.id_pc);
        end
    endtask

    // Random traffic against a queue model: every accepted, non-flushed fetch is delivered in order.
    task automatic test_random();
        logic [63:0] q [$];
        logic [31:0] exp_next, cur_addr, rpc;
        logic        in_flight, keep, rdy, rv, rs;
        int          n_xfer;
        ack_force = -1; mem_wait = 0; max_wait = 3; rand_data = 1'b1;
        do_reset(1'b0);
        exp_next = 32'h0; cur_addr = 32'h0; in_flight = 1'b0; keep = 1'b0; n_xfer = 0;
        for (int i = 0; i < 3000; i++) begin
            rdy = ($urandom_range(0, 3) != 0);
            rv  = ($urandom_range(0, 40) == 0);
            rpc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
            rs  = ($urandom_range(0, 400) == 0);
            tick(rs, rdy, rv, rpc);

            n_tests++;
            if (bus_if.id_valid !== (q.size() != 0)) begin
                n_fail++; $display("FAIL rand_valid[%0d]: got %0d expected %0d", i, bus_if.id_valid, q.size() != 0);
            end else if (bus_if.id_valid) begin
                n_tests++;
                if ({bus_if.id_pc, bus_if.id_instr} !== q[0]) begin
                    n_fail++; $display("FAIL rand_head[%0d]: pc/instr got %h/%h expected %h/%h", i, bus_if.id_pc, bus_if.id_instr, q[0][63:32], q[0][31:0]);
                end
            end else begin
                n_tests++;
                if ({bus_if.id_pc, bus_if.id_instr} !== 64'h0) begin
                    n_fail++; $display("FAIL rand_idle_zero[%0d]: pc/instr got %h/%h expected 0/0", i, bus_if.id_pc, bus_if.id_instr);
                end
            end

            if (bus_if.imem_req) begin
                n_tests++;
                if (!in_flight) begin
                    if (bus_if.imem_addr !== exp_next) begin
                        n_fail++; $display("FAIL rand_req_addr[%0d]: got %h expected %h", i, bus_if.imem_addr, exp_next);
                    end
                    cur_addr = exp_next; exp_next += 32'd4; in_flight = 1'b1; keep = 1'b1;
                end else if (bus_if.imem_addr !== cur_addr) begin
                    n_fail++; $display("FAIL rand_req_hold[%0d]: got %h expected %h", i, bus_if.imem_addr, cur_addr);
                end
            end else if (in_flight) begin
                n_tests++; n_fail++;
                $display("FAIL rand_req_dropped[%0d]: req got 0 expected 1", i);
            end

            if (rs) begin
                q.delete(); exp_next = 32'h0; in_flight = 1'b0; keep = 1'b0;
            end else begin
                if (rv) begin
                    q.delete(); exp_next = rpc; keep = 1'b0;
                end else if (bus_if.id_valid && rdy && q.size() != 0) begin
                    void'(q.pop_front());
                end
                if (bus_if.imem_req && bus_if.imem_ack) begin
                    if (keep) q.push_back({cur_addr, bus_if.imem_rdata});
                    in_flight = 1'b0;
                    n_xfer++;
                end
            end
        end
        n_tests++;
        if (n_xfer < 300) begin
            n_fail++; $display("FAIL rand_progress: xfers got %0d expected at least 300", n_xfer);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_tests = 0; n_fail = 0;
        rst = 1'b1;
        bus_if.imem_ack = 1'b0; bus_if.imem_rdata = 32'h0;
        bus_if.redirect_valid = 1'b0; bus_if.redirect_pc = 32'h0; bus_if.id_ready = 1'b0;
        mem_wait = 0; max_wait = 0; wcnt = 0; ack_force = -1; ack_tie = 1'b0; rand_data = 1'b0;

        test_reset();
        test_boot();
        test_full_stall();
        test_wait_states();
        test_redirect_midflight();
        test_same_cycle();
        test_pc_wrap();
        test_reset_midop();
        test_random();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
